wm_cycle_controller: RTL and testbench

- Parametrised next-generation washing-machine controller: a Moore FSM with on-chip phase timers.
- Replaces the external cycle_time_out/spin_time_out strobes with an internal timer.
- Adds a configurable rinse count, pause/resume, abort-with-drain, and fill/drain watchdogs with error codes.
- Sits between the front-panel/sensor inputs and the valve/motor/lock actuator drivers.

---
 rtl/wm_pkg.sv | 43 ++++
 rtl/wm_phase_timer.sv | 52 +++++
 rtl/wm_cycle_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_wm_cycle_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// wm_pkg: shared definitions for the washing-machine cycle controller.
//   - state_e   : FSM state encoding; the values are visible on state_o.
//   - ERR_*     : err_code values reported when the FSM enters ERROR.
//   - DEF_*     : default phase durations and watchdog limits, in clocks.
//   - is_run_state : true for the sequenced wash states FILL_SOAP..SPIN.
package wm_pkg;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_CHECK_DOOR  = 4'd1,
        S_FILL_SOAP   = 4'd2,
        S_DETERGENT   = 4'd3,
        S_WASH        = 4'd4,
        S_DRAIN_SOAP  = 4'd5,
        S_FILL_RINSE  = 4'd6,
        S_RINSE       = 4'd7,
        S_DRAIN_RINSE = 4'd8,
        S_SPIN        = 4'd9,
        S_DONE        = 4'd10,
        S_ERROR       = 4'd11,
        S_PAUSED      = 4'd12,
        S_ABORT_DRAIN = 4'd13
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FILL  = 2'd1;
    localparam logic [1:0] ERR_DRAIN = 2'd2;
    localparam logic [1:0] ERR_DOOR  = 2'd3;

    localparam int DEF_CNT_W     = 16;
    localparam int DEF_WASH_CYC  = 500;
    localparam int DEF_RINSE_CYC = 300;
    localparam int DEF_SPIN_CYC  = 400;
    localparam int DEF_FILL_TMO  = 1000;
    localparam int DEF_DRAIN_TMO = 800;
    localparam int DEF_RINSE_W   = 2;

    // The states that can be paused; the encodings are contiguous on purpose.
    function automatic logic is_run_state(input state_e s);
        return (s >= S_FILL_SOAP) && (s <= S_SPIN);
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: saturating phase timer with one expire flag per limit.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear           : restart from 0 (wins over hold)
//   hold            : freeze the current count
//   count           : current timer value
//   wash_exp ..     : high when count == limit-1 for that phase/watchdog
module wm_phase_timer #(
    parameter int CNT_W     = 16,
    parameter int WASH_CYC  = 500,
    parameter int RINSE_CYC = 300,
    parameter int SPIN_CYC  = 400,
    parameter int FILL_TMO  = 1000,
    parameter int DRAIN_TMO = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             hold,
    output logic [CNT_W-1:0] count,
    output logic             wash_exp,
    output logic             rinse_exp,
    output logic             spin_exp,
    output logic             fill_exp,
    output logic             drain_exp
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is written with <= only, so every register in
    // this always_ff samples the pre-edge values and ordering cannot matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (!hold && (r_count != '1)) begin
            // Saturate instead of wrapping so a stuck phase never re-fires.
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count     = r_count;
    // Flags fire at limit-1: the phase then lasts exactly `limit` clocks,
    // counting the first clock of the state as timer value 0.
    assign wash_exp  = (r_count == CNT_W'(WASH_CYC  - 1));
    assign rinse_exp = (r_count == CNT_W'(RINSE_CYC - 1));
    assign spin_exp  = (r_count == CNT_W'(SPIN_CYC  - 1));
    assign fill_exp  = (r_count == CNT_W'(FILL_TMO  - 1));
    assign drain_exp = (r_count == CNT_W'(DRAIN_TMO - 1));

endmodule

// File: rtl/wm_cycle_controller.sv
// wm_cycle_controller: Moore FSM sequencing a wash cycle
// (fill, detergent, wash, drain, N rinses, spin) with pause/resume,
// abort-with-drain, fill/drain watchdogs and door-open fault detection.
// Inputs : clk, reset (sync, active high), start, door_close, filled,
//          detergent_added, drained, num_rinses, pause, abort
// Outputs: door_lock, fill_valve_on, drain_valve_on, motor_on, soap_wash,
//          water_wash, done, error (decoded from state), err_code,
//          state_o, rinse_cnt_o
module wm_cycle_controller
    import wm_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WASH_CYC  = DEF_WASH_CYC,
    parameter int RINSE_CYC = DEF_RINSE_CYC,
    parameter int SPIN_CYC  = DEF_SPIN_CYC,
    parameter int FILL_TMO  = DEF_FILL_TMO,
    parameter int DRAIN_TMO = DEF_DRAIN_TMO,
    parameter int RINSE_W   = DEF_RINSE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               door_close,
    input  logic               filled,
    input  logic               detergent_added,
    input  logic               drained,
    input  logic [RINSE_W-1:0] num_rinses,
    input  logic               pause,
    input  logic               abort,
    output logic               door_lock,
    output logic               fill_valve_on,
    output logic               drain_valve_on,
    output logic               motor_on,
    output logic               soap_wash,
    output logic               water_wash,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [3:0]         state_o,
    output logic [RINSE_W-1:0] rinse_cnt_o
);

    state_e             r_state;
    state_e             r_saved_state;
    logic [RINSE_W-1:0] r_num_rinses;
    logic [RINSE_W-1:0] r_rinse_cnt;
    logic [1:0]         r_err_code;

    state_e             w_next_state;
    logic [1:0]         w_err_val;
    logic               w_rinse_inc;
    logic               w_pausing;
    logic               w_resuming;
    logic               w_timer_clear;
    logic               w_timer_hold;
    logic               w_door_guarded;
    logic [RINSE_W:0]   w_rinse_next;
    logic               w_wash_exp;
    logic               w_rinse_exp;
    logic               w_spin_exp;
    logic               w_fill_exp;
    logic               w_drain_exp;
    // The FSM only needs the expire flags; the raw count is left unused here.
    logic [CNT_W-1:0]   w_unused_timer_count;

    wm_phase_timer #(
        .CNT_W     (CNT_W),
        .WASH_CYC  (WASH_CYC),
        .RINSE_CYC (RINSE_CYC),
        .SPIN_CYC  (SPIN_CYC),
        .FILL_TMO  (FILL_TMO),
        .DRAIN_TMO (DRAIN_TMO)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_timer_clear),
        .hold      (w_timer_hold),
        .count     (w_unused_timer_count),
        .wash_exp  (w_wash_exp),
        .rinse_exp (w_rinse_exp),
        .spin_exp  (w_spin_exp),
        .fill_exp  (w_fill_exp),
        .drain_exp (w_drain_exp)
    );

    // Door-open while locked is a fault, except in PAUSED where the user
    // may legitimately be waiting with the door held.
    assign w_door_guarded = is_run_state(r_state) || (r_state == S_ABORT_DRAIN);
    // One bit wider so the maximum rinse count cannot wrap in the compare.
    assign w_rinse_next   = {1'b0, r_rinse_cnt} + (RINSE_W+1)'(1);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_err_val    = ERR_NONE;
        w_rinse_inc  = 1'b0;

        if (abort && (r_state != S_IDLE) && (r_state != S_ERROR)) begin
            w_next_state = S_ABORT_DRAIN;
        end else if (w_door_guarded && !door_close) begin
            w_next_state = S_ERROR;
            w_err_val    = ERR_DOOR;
        end else if (pause && is_run_state(r_state)) begin
            w_next_state = S_PAUSED;
        end else begin
            unique case (r_state)
                S_IDLE:       if (start) w_next_state = S_CHECK_DOOR;
                S_CHECK_DOOR: if (door_close) w_next_state = S_FILL_SOAP;
                S_FILL_SOAP: begin
                    if (filled) begin
                        w_next_state = S_DETERGENT;
                    end else if (w_fill_exp) begin
                        w_next_state = S_ERROR;
                        w_err_val    = ERR_FILL;
                    end
                end
                S_DETERGENT:  if (detergent_added) w_next_state = S_WASH;
                S_WASH:       if (w_wash_exp) w_next_state = S_DRAIN_SOAP;
                S_DRAIN_SOAP: begin
                    if (drained) begin
                        w_next_state = (r_num_rinses != '0) ? S_FILL_RINSE : S_SPIN;
                    end else if (w_drain_exp) begin
                        w_next_state = S_ERROR;
                        w_err_val    = ERR_DRAIN;
                    end
                end
                S_FILL_RINSE: begin
                    if (filled) begin
                        w_next_state = S_RINSE;
                    end else if (w_fill_exp) begin
                        w_next_state = S_ERROR;
                        w_err_val    = ERR_FILL;
                    end
                end
                S_RINSE:      if (w_rinse_exp) w_next_state = S_DRAIN_RINSE;
                S_DRAIN_RINSE: begin
                    if (drained) begin
                        w_rinse_inc  = 1'b1;
                        w_next_state = (w_rinse_next < {1'b0, r_num_rinses})
                                       ? S_FILL_RINSE : S_SPIN;
                    end else if (w_drain_exp) begin
                        w_next_state = S_ERROR;
                        w_err_val    = ERR_DRAIN;
                    end
                end
                S_SPIN:       if (w_spin_exp) w_next_state = S_DONE;
                S_DONE:       if (!door_close) w_next_state = S_IDLE;
                S_ERROR:      w_next_state = S_ERROR;
                S_PAUSED:     if (!pause) w_next_state = r_saved_state;
                S_ABORT_DRAIN: begin
                    if (drained) begin
                        w_next_state = S_IDLE;
                    end else if (w_drain_exp) begin
                        w_next_state = S_ERROR;
                        w_err_val    = ERR_DRAIN;
                    end
                end
                default:      w_next_state = S_ERROR;
            endcase
        end
    end

    // Entering and leaving PAUSED must keep the interrupted phase's elapsed
    // time; every other state change restarts the timer.
    assign w_pausing     = (w_next_state == S_PAUSED) && (r_state != S_PAUSED);
    assign w_resuming    = (r_state == S_PAUSED) && (w_next_state == r_saved_state);
    assign w_timer_clear = (w_next_state != r_state) && !w_pausing && !w_resuming;
    assign w_timer_hold  = (r_state == S_PAUSED) || w_pausing;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_saved_state <= S_IDLE;
            r_num_rinses  <= '0;
            r_rinse_cnt   <= '0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_pausing) begin
                r_saved_state <= r_state;
            end
            if ((r_state == S_IDLE) && (w_next_state == S_CHECK_DOOR)) begin
                r_num_rinses <= num_rinses;
                r_rinse_cnt  <= '0;
            end else if (w_rinse_inc) begin
                r_rinse_cnt <= w_rinse_next[RINSE_W-1:0];
            end
            if ((w_next_state == S_ERROR) && (r_state != S_ERROR)) begin
                r_err_code <= w_err_val;
            end
        end
    end

    // Moore outputs: pure decode of the state register.
    always_comb begin
        door_lock      = 1'b0;
        fill_valve_on  = 1'b0;
        drain_valve_on = 1'b0;
        motor_on       = 1'b0;
        soap_wash      = 1'b0;
        water_wash     = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        unique case (r_state)
            S_FILL_SOAP:   begin door_lock = 1'b1; fill_valve_on = 1'b1; end
            S_DETERGENT:   begin door_lock = 1'b1; soap_wash = 1'b1; end
            S_WASH:        begin door_lock = 1'b1; motor_on = 1'b1; soap_wash = 1'b1; end
            S_DRAIN_SOAP:  begin door_lock = 1'b1; drain_valve_on = 1'b1; end
            S_FILL_RINSE:  begin door_lock = 1'b1; fill_valve_on = 1'b1; water_wash = 1'b1; end
            S_RINSE:       begin door_lock = 1'b1; motor_on = 1'b1; water_wash = 1'b1; end
            S_DRAIN_RINSE: begin door_lock = 1'b1; drain_valve_on = 1'b1; end
            S_SPIN:        begin door_lock = 1'b1; motor_on = 1'b1; drain_valve_on = 1'b1; end
            S_DONE:        done = 1'b1;
            S_ERROR:       error = 1'b1;
            S_PAUSED:      door_lock = 1'b1;
            S_ABORT_DRAIN: begin door_lock = 1'b1; drain_valve_on = 1'b1; end
            default:       ;
        endcase
    end

    assign err_code    = r_err_code;
    assign state_o     = r_state;
    assign rinse_cnt_o = r_rinse_cnt;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Directed testbench for wm_cycle_controller with short phase durations.
module tb_wm_cycle_controller;

    localparam int ST_IDLE = 0, ST_CHECK_DOOR = 1, ST_FILL_SOAP = 2, ST_DETERGENT = 3;
    localparam int ST_WASH = 4, ST_DRAIN_SOAP = 5, ST_FILL_RINSE = 6, ST_RINSE = 7;
    localparam int ST_DRAIN_RINSE = 8, ST_SPIN = 9, ST_DONE = 10, ST_ERROR = 11;
    localparam int ST_PAUSED = 12, ST_ABORT_DRAIN = 13;

    // Actuator vector: {lock, fill, drain, motor, soap, water, done, error}
    localparam logic [7:0] A_NONE  = 8'b0000_0000;
    localparam logic [7:0] A_FILLS = 8'b1100_0000;
    localparam logic [7:0] A_DET   = 8'b1000_1000;
    localparam logic [7:0] A_WASH  = 8'b1001_1000;
    localparam logic [7:0] A_DRAIN = 8'b1010_0000;
    localparam logic [7:0] A_FILLR = 8'b1100_0100;
    localparam logic [7:0] A_RINSE = 8'b1001_0100;
    localparam logic [7:0] A_SPIN  = 8'b1011_0000;
    localparam logic [7:0] A_DONE  = 8'b0000_0010;
    localparam logic [7:0] A_ERR   = 8'b0000_0001;
    localparam logic [7:0] A_PAUSE = 8'b1000_0000;

    logic       clk = 1'b0;
    logic       reset, start, door_close, filled, detergent_added, drained, pause, abort;
    logic [1:0] num_rinses;
    logic       door_lock, fill_valve_on, drain_valve_on, motor_on;
    logic       soap_wash, water_wash, done, error;
    logic [1:0] err_code;
    logic [3:0] state_o;
    logic [1:0] rinse_cnt_o;

    int checks = 0;
    int errors = 0;
    int n;
    logic water_seen;

    wire [7:0] acts = {door_lock, fill_valve_on, drain_valve_on, motor_on,
                       soap_wash, water_wash, done, error};

    always #5 clk = ~clk;

    always @(posedge clk) if (water_wash) water_seen = 1'b1;

    wm_cycle_controller #(
        .CNT_W(16), .WASH_CYC(8), .RINSE_CYC(8), .SPIN_CYC(8),
        .FILL_TMO(20), .DRAIN_TMO(30), .RINSE_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .door_close(door_close),
        .filled(filled), .detergent_added(detergent_added), .drained(drained),
        .num_rinses(num_rinses), .pause(pause), .abort(abort),
        .door_lock(door_lock), .fill_valve_on(fill_valve_on),
        .drain_valve_on(drain_valve_on), .motor_on(motor_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
        .error(error), .err_code(err_code), .state_o(state_o),
        .rinse_cnt_o(rinse_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_state(input int st, output int cnt);
        cnt = 0;
        while ((state_o == 4'(st)) && (cnt < 200)) begin
            cnt++;
            tick();
        end
    endtask

    // IDLE -> CHECK_DOOR -> FILL_SOAP -> DETERGENT -> WASH with handshakes.
    task automatic run_to_wash(input logic [1:0] nr);
        num_rinses = nr;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("check_door_state", 32'(state_o), ST_CHECK_DOOR);
        check("check_door_unlocked", 32'(door_lock), 0);
        door_close = 1'b1;
        tick();
        check("fill_soap_acts", 32'(acts), 32'(A_FILLS));
        filled = 1'b1;
        tick();
        filled = 1'b0;
        check("detergent_acts", 32'(acts), 32'(A_DET));
        detergent_added = 1'b1;
        tick();
        detergent_added = 1'b0;
        check("wash_state", 32'(state_o), ST_WASH);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; door_close = 1'b0; filled = 1'b0;
        detergent_added = 1'b0; drained = 1'b0; pause = 1'b0; abort = 1'b0;
        num_rinses = 2'd0;
        tick(); tick();
        reset = 1'b0;
        check("reset_state", 32'(state_o), ST_IDLE);
        check("reset_acts", 32'(acts), 32'(A_NONE));
        check("reset_err_code", 32'(err_code), 0);
        check("reset_rinse_cnt", 32'(rinse_cnt_o), 0);

        // ---- Full cycle with two rinses ----
        water_seen = 1'b0;
        run_to_wash(2'd2);
        check("wash_acts", 32'(acts), 32'(A_WASH));
        count_state(ST_WASH, n);
        check("wash_len", n, 8);
        check("drain_soap_acts", 32'(acts), 32'(A_DRAIN));
        drained = 1'b1; tick(); drained = 1'b0;
        for (int p = 0; p < 2; p++) begin
            check("fill_rinse_state", 32'(state_o), ST_FILL_RINSE);
            check("fill_rinse_acts", 32'(acts), 32'(A_FILLR));
            filled = 1'b1; tick(); filled = 1'b0;
            check("rinse_acts", 32'(acts), 32'(A_RINSE));
            count_state(ST_RINSE, n);
            check("rinse_len", n, 8);
            check("drain_rinse_state", 32'(state_o), ST_DRAIN_RINSE);
            drained = 1'b1; tick(); drained = 1'b0;
            check("rinse_cnt_pass", 32'(rinse_cnt_o), p + 1);
        end
        check("spin_acts", 32'(acts), 32'(A_SPIN));
        count_state(ST_SPIN, n);
        check("spin_len", n, 8);
        check("done_state", 32'(state_o), ST_DONE);
        check("done_acts", 32'(acts), 32'(A_DONE));
        check("done_rinse_cnt", 32'(rinse_cnt_o), 2);
        check("water_seen_full", 32'(water_seen), 1);
        tick();
        check("done_holds_closed", 32'(state_o), ST_DONE);
        door_close = 1'b0; tick();
        check("done_to_idle", 32'(state_o), ST_IDLE);

        // ---- Zero rinses: DRAIN_SOAP goes straight to SPIN ----
        water_seen = 1'b0;
        run_to_wash(2'd0);
        count_state(ST_WASH, n);
        drained = 1'b1; tick(); drained = 1'b0;
        check("no_rinse_spin", 32'(state_o), ST_SPIN);
        count_state(ST_SPIN, n);
        check("no_rinse_done", 32'(state_o), ST_DONE);
        check("no_rinse_cnt", 32'(rinse_cnt_o), 0);
        check("no_water_wash", 32'(water_seen), 0);
        door_close = 1'b0; tick();

        // ---- Fill watchdog ----
        num_rinses = 2'd1; start = 1'b1; tick(); start = 1'b0;
        door_close = 1'b1; tick();
        count_state(ST_FILL_SOAP, n);
        check("fill_tmo_len", n, 20);
        check("fill_tmo_state", 32'(state_o), ST_ERROR);
        check("fill_tmo_acts", 32'(acts), 32'(A_ERR));
        check("fill_tmo_code", 32'(err_code), 1);
        start = 1'b1; door_close = 1'b0; filled = 1'b1;
        repeat (5) tick();
        start = 1'b0; filled = 1'b0;
        check("error_sticky", 32'(state_o), ST_ERROR);
        reset = 1'b1; tick(); reset = 1'b0;
        check("error_reset_state", 32'(state_o), ST_IDLE);
        check("error_reset_code", 32'(err_code), 0);

        // ---- Pause at WASH timer=3, then door fault in RINSE ----
        run_to_wash(2'd1);
        repeat (3) tick();
        pause = 1'b1; tick();
        check("paused_state", 32'(state_o), ST_PAUSED);
        check("paused_acts", 32'(acts), 32'(A_PAUSE));
        repeat (9) tick();
        check("paused_still", 32'(state_o), ST_PAUSED);
        pause = 1'b0; tick();
        count_state(ST_WASH, n);
        check("wash_after_resume", n, 5);
        drained = 1'b1; tick(); drained = 1'b0;
        filled = 1'b1; tick(); filled = 1'b0;
        check("rinse_before_fault", 32'(state_o), ST_RINSE);
        tick(); tick();
        door_close = 1'b0; tick();
        check("door_fault_state", 32'(state_o), ST_ERROR);
        check("door_fault_code", 32'(err_code), 3);
        check("door_fault_acts", 32'(acts), 32'(A_ERR));
        reset = 1'b1; tick(); reset = 1'b0;

        // ---- Abort in WASH ----
        run_to_wash(2'd0);
        tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_state", 32'(state_o), ST_ABORT_DRAIN);
        check("abort_acts", 32'(acts), 32'(A_DRAIN));
        tick();
        check("abort_waits_drain", 32'(state_o), ST_ABORT_DRAIN);
        drained = 1'b1; tick(); drained = 1'b0;
        check("abort_idle", 32'(state_o), ST_IDLE);
        check("abort_unlocked", 32'(door_lock), 0);

        // ---- Reset during SPIN ----
        run_to_wash(2'd0);
        count_state(ST_WASH, n);
        drained = 1'b1; tick(); drained = 1'b0;
        check("spin_before_reset", 32'(state_o), ST_SPIN);
        tick(); tick();
        reset = 1'b1; tick();
        check("spin_reset_state", 32'(state_o), ST_IDLE);
        check("spin_reset_acts", 32'(acts), 32'(A_NONE));
        reset = 1'b0; tick();
        check("idle_after_reset", 32'(state_o), ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
